// File: rtl/kv_cmd_scheduler.sv
// Four-requester round-robin command scheduler for a key/value store.
// One operation is in flight at a time: grant, launch, wait for the store or time out, then respond.
module kv_cmd_scheduler #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [3:0]   req_i,
  input  logic [127:0] req_key_i,
  input  logic [127:0] req_value_i,
  input  logic [3:0]   req_kind_i,
  output logic [3:0]   ack_o,
  output logic [31:0]  rsp_value_o,
  output logic         rsp_ok_o,
  output logic         busy_o,
  output logic         st_enable_o,
  output logic         st_write_o,
  output logic [1:0]   st_signal_o,
  output logic [31:0]  st_key_o,
  output logic [31:0]  st_value_o,
  output logic         st_kind_o,
  input  logic         st_ready_i,
  input  logic [31:0]  st_rdata_i,
  output logic [15:0]  ops_done_o,
  output logic [7:0]   timeouts_o
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [1:0]  rr_q, idx_q;
  logic [7:0]  timer_q;
  logic [3:0]  ack_q;
  logic [31:0] rsp_value_q, st_key_q, st_value_q;
  logic        rsp_ok_q, busy_q, st_enable_q, st_write_q, st_kind_q;
  logic [1:0]  st_signal_q;
  logic [15:0] ops_done_q, ops_done_d;
  logic [7:0]  timeouts_q, timeouts_d;

  logic        gnt_found;
  logic [1:0]  gnt_idx, scan_idx;

  // Request bit k carries opcode k+1; map it to the store's signal encoding.
  function automatic logic [1:0] op_signal(input logic [1:0] idx);
    case (idx)
      2'd0:    op_signal = 2'b10;
      2'd1:    op_signal = 2'b11;
      2'd2:    op_signal = 2'b00;
      default: op_signal = 2'b01;
    endcase
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    scan_idx  = rr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_q + 2'(i);
      if (!gnt_found && req_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Counters settle together with the transition into RESP so they are current alongside ack.
  always_comb begin
    ops_done_d = ops_done_q;
    timeouts_d = timeouts_q;
    if (state_q == WAIT) begin
      if (st_ready_i) begin
        if (ops_done_q != 16'hFFFF) ops_done_d = ops_done_q + 16'd1;
      end else if (timer_q == TMAX) begin
        if (timeouts_q != 8'hFF) timeouts_d = timeouts_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      ack_q       <= '0;
      rsp_value_q <= '0;
      rsp_ok_q    <= 1'b0;
      busy_q      <= 1'b0;
      st_enable_q <= 1'b0;
      st_write_q  <= 1'b0;
      st_signal_q <= '0;
      st_key_q    <= '0;
      st_value_q  <= '0;
      st_kind_q   <= 1'b0;
      ops_done_q  <= '0;
      timeouts_q  <= '0;
    end else begin
      ack_q       <= '0;
      st_enable_q <= 1'b0;
      st_write_q  <= 1'b0;
      ops_done_q  <= ops_done_d;
      timeouts_q  <= timeouts_d;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            idx_q       <= gnt_idx;
            rr_q        <= gnt_idx + 2'd1;
            st_key_q    <= req_key_i[{gnt_idx, 5'b0} +: 32];
            st_value_q  <= req_value_i[{gnt_idx, 5'b0} +: 32];
            st_kind_q   <= req_kind_i[gnt_idx];
            st_signal_q <= op_signal(gnt_idx);
            st_enable_q <= 1'b1;
            st_write_q  <= (gnt_idx != 2'd2);
            busy_q      <= 1'b1;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (st_ready_i) begin
            rsp_value_q <= st_rdata_i;
            rsp_ok_q    <= 1'b1;
            ack_q       <= 4'b0001 << idx_q;
            state_q     <= RESP;
          end else if (timer_q == TMAX) begin
            rsp_value_q <= '0;
            rsp_ok_q    <= 1'b0;
            ack_q       <= 4'b0001 << idx_q;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o       = ack_q;
  assign rsp_value_o = rsp_value_q;
  assign rsp_ok_o    = rsp_ok_q;
  assign busy_o      = busy_q;
  assign st_enable_o = st_enable_q;
  assign st_write_o  = st_write_q;
  assign st_signal_o = st_signal_q;
  assign st_key_o    = st_key_q;
  assign st_value_o  = st_value_q;
  assign st_kind_o   = st_kind_q;
  assign ops_done_o  = ops_done_q;
  assign timeouts_o  = timeouts_q;

endmodule

// File: tb/tb_kv_cmd_scheduler.sv
// Scoreboard bench for kv_cmd_scheduler: a request-level model predicts grant order,
// store traffic and responses; a store model checks launches and a monitor checks acks.
module tb_kv_cmd_scheduler;
  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] req_key = '0, req_value = '0;
  logic [3:0]   req_kind = '0;
  logic [3:0]   ack;
  logic [31:0]  rsp_value;
  logic         rsp_ok, busy, st_enable, st_write, st_kind;
  logic [1:0]   st_signal;
  logic [31:0]  st_key, st_value;
  logic         st_ready = 1'b0;
  logic [31:0]  st_rdata = '0;
  logic [15:0]  ops_done;
  logic [7:0]   timeouts;

  kv_cmd_scheduler #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_key_i(req_key),
    .req_value_i(req_value), .req_kind_i(req_kind), .ack_o(ack),
    .rsp_value_o(rsp_value), .rsp_ok_o(rsp_ok), .busy_o(busy),
    .st_enable_o(st_enable), .st_write_o(st_write), .st_signal_o(st_signal),
    .st_key_o(st_key), .st_value_o(st_value), .st_kind_o(st_kind),
    .st_ready_i(st_ready), .st_rdata_i(st_rdata), .ops_done_o(ops_done),
    .timeouts_o(timeouts)
  );

  typedef struct {
    logic [3:0] ack; logic ok; logic [31:0] val; logic [15:0] ops; logic [7:0] tmo;
  } exp_t;
  typedef struct {
    int dly; logic [31:0] rdata, key, val; logic kind; logic [1:0] sig; logic wr;
  } plan_t;

  exp_t  expq[$];
  plan_t planq[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  bit started = 1'b0;

  int          m_rr = 0;
  logic [15:0] m_ops = '0;
  logic [7:0]  m_tmo = '0;
  logic [1:0]  sig_tab[4] = '{2'b10, 2'b11, 2'b00, 2'b01};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every ack pulse consumes one predicted response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (started && !reset && ack !== 4'b0) begin
      last_ack_cyc = cyc;
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL ack_unexpected: got ack=%b expected none", ack);
      end else begin
        e = expq.pop_front();
        chk("ack", 32'(ack), 32'(e.ack));
        chk("rsp_ok", 32'(rsp_ok), 32'(e.ok));
        chk("rsp_value", rsp_value, e.val);
        chk("ops_done", 32'(ops_done), 32'(e.ops));
        chk("timeouts", 32'(timeouts), 32'(e.tmo));
        chk("busy_in_resp", 32'(busy), 32'd1);
      end
    end
  end

  // Store model: checks each launch against the plan and answers after plan.dly WAIT cycles.
  bit          armed = 1'b0;
  int          cnt = 0;
  logic [31:0] rdat = '0;
  always @(negedge clk) begin : store
    plan_t p;
    if (started) begin
      st_ready = 1'b0;
      if (armed) begin
        if (cnt == 0) begin
          st_ready = 1'b1;
          st_rdata = rdat;
          armed    = 1'b0;
        end else cnt--;
      end
      if (!reset && !st_enable && st_write) begin
        total++; bad++;
        $display("FAIL st_write_outside_launch: got 1 expected 0");
      end
      if (!reset && st_enable) begin
        if (planq.size() == 0) begin
          total++; bad++;
          $display("FAIL launch_unexpected: got st_enable=1 expected 0");
        end else begin
          p = planq.pop_front();
          chk("st_signal", 32'(st_signal), 32'(p.sig));
          chk("st_write", 32'(st_write), 32'(p.wr));
          chk("st_key", st_key, p.key);
          chk("st_value", st_value, p.val);
          chk("st_kind", 32'(st_kind), 32'(p.kind));
          armed = (p.dly != NEVER);
          cnt   = p.dly;
          rdat  = p.rdata;
        end
      end
    end
  end

  function automatic int pick_dly();
    case ($urandom_range(0, 8))
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      4: return TO - 2;
      5: return TO - 1;
      6: return TO;
      7: return TO + 1;
      default: return NEVER;
    endcase
  endfunction

  // Presents a batch of requests at once, predicts the full response sequence,
  // then drops each req bit as its ack appears.
  task automatic batch(input logic [3:0] mask, input int fixed_dly, output int start);
    int dl[4];
    logic [3:0] rem;
    int g;
    bit ok;
    plan_t p;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      req_key[32*k +: 32]   = $urandom;
      req_value[32*k +: 32] = $urandom;
      req_kind[k]           = 1'($urandom);
      dl[k] = (fixed_dly >= 0) ? fixed_dly : pick_dly();
    end
    rem = mask;
    while (rem != 0) begin
      g = -1;
      for (int i = 0; i < 4; i++)
        if (g < 0 && rem[(m_rr + i) % 4]) g = (m_rr + i) % 4;
      rem[g] = 1'b0;
      m_rr   = (g + 1) % 4;
      ok     = dl[g] < TO;
      p.dly  = dl[g];
      p.rdata = $urandom;
      p.key  = req_key[32*g +: 32];
      p.val  = req_value[32*g +: 32];
      p.kind = req_kind[g];
      p.sig  = sig_tab[g];
      p.wr   = (g != 2);
      if (ok) begin if (m_ops != 16'hFFFF) m_ops++; end
      else    begin if (m_tmo != 8'hFF)    m_tmo++; end
      e.ack = 4'(1 << g);
      e.ok  = ok;
      e.val = ok ? p.rdata : 32'd0;
      e.ops = m_ops;
      e.tmo = m_tmo;
      planq.push_back(p);
      expq.push_back(e);
    end
    start = cyc;
    req = mask;
    for (int t = 0; t < 400 && req != 0; t++) begin
      @(negedge clk);
      req = req & ~ack;
    end
    if (req != 0) begin
      total++; bad++;
      $display("FAIL batch_wait: got pending req=%b expected 0000", req);
      req = '0;
    end
    @(negedge clk);
  endtask

  initial begin
    int st;
    plan_t p;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    started = 1'b1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_st_enable", 32'(st_enable), 32'd0);
    chk("rst_rsp", {rsp_value[30:0], rsp_ok}, 32'd0);
    chk("rst_st_key", st_key, 32'd0);
    chk("rst_counters", {8'd0, ops_done, timeouts}, 32'd0);
    repeat (2) @(negedge clk);
    chk("idle_no_req_busy", 32'(busy), 32'd0);

    // Round robin from rr=0, store answers at once; also the minimum latency.
    batch(4'b1111, 0, st);
    batch(4'b0001, 0, st);
    chk("latency_min", 32'(last_ack_cyc - st), 32'd3);
    // Single create answered two cycles after launch.
    batch(4'b1000, 1, st);
    // Refer read.
    batch(4'b0100, 0, st);
    // Timeout with no store answer.
    batch(4'b0010, NEVER, st);
    chk("latency_timeout", 32'(last_ack_cyc - st), 32'(TO + 2));
    // Boundary: answer on the last allowed WAIT cycle, then one cycle too late.
    batch(4'b0001, TO - 1, st);
    batch(4'b0001, TO, st);

    // Reset mid-WAIT, then a late st_ready must be ignored.
    req_key[63:32] = $urandom; req_value[63:32] = $urandom; req_kind[1] = 1'b1;
    p.dly = 5; p.rdata = 32'h1234_5678; p.key = req_key[63:32]; p.val = req_value[63:32];
    p.kind = 1'b1; p.sig = 2'b11; p.wr = 1'b1;
    planq.push_back(p);
    req = 4'b0010;
    repeat (4) @(negedge clk);
    reset = 1'b1; req = '0;
    @(negedge clk);
    reset = 1'b0;
    m_rr = 0; m_ops = '0; m_tmo = '0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_counters", {8'd0, ops_done, timeouts}, 32'd0);
    repeat (8) @(negedge clk);
    chk("rst_late_ready_busy", 32'(busy), 32'd0);
    chk("rst_late_ready_counters", {8'd0, ops_done, timeouts}, 32'd0);
    batch(4'b1111, 0, st);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      batch(m, -1, st);
    end

    // Drive the abort counter into saturation.
    for (int n = 0; n < 66; n++) batch(4'b1111, NEVER, st);

    // Preload the success counter just below saturation, then complete two more.
    force dut.ops_done_q = 16'hFFFE;
    @(negedge clk);
    release dut.ops_done_q;
    m_ops = 16'hFFFE;
    batch(4'b0001, 0, st);
    batch(4'b0010, 2, st);

    repeat (5) @(negedge clk);
    chk("expq_empty", 32'(expq.size()), 32'd0);
    chk("planq_empty", 32'(planq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/kv_cmd_scheduler.md
KV_CMD_SCHEDULER -- requirements
Module: kv_cmd_scheduler

Interface
REQ-001 Parameter: TIMEOUT, 16, WAIT-state cycles allowed before an operation is aborted (range 2..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-command request, held until ack; bit0=issue, bit1=transfer, bit2=refer, bit3=create (bit k = opcode k+1).
REQ-005 req_key  input  128  packed 4x32 keys; bits [32k+31:32k] belong to requester k.
REQ-006 req_value  input  128  packed 4x32 value/transact_value; bits [32k+31:32k] belong to requester k.
REQ-007 req_kind  input  4  transact_kind per requester.
REQ-008 ack  output  4  one-cycle completion pulse to the granted requester.
REQ-009 rsp_value  output  32  value returned by the store for the completed operation.
REQ-010 rsp_ok  output  1  1 = store completed the operation, 0 = timeout abort; valid with ack.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 st_enable  output  1  store enable pulse.
REQ-013 st_write  output  1  store write enable, valid with st_enable.
REQ-014 st_signal  output  2  op code to store: 00 refer, 01 create, 10 issue, 11 transfer.
REQ-015 st_key, st_value  output  32 each  latched key and value/transact_value.
REQ-016 st_kind  output  1  latched transact_kind.
REQ-017 st_ready  input  1  store completion pulse.
REQ-018 st_rdata  input  32  store read/updated value, valid with st_ready.
REQ-019 ops_done  output  16  count of successful operations; timeouts  output  8  count of aborts.

Function
REQ-020 FSM states IDLE, LAUNCH, WAIT, RESP; all outputs registered.
REQ-021 IDLE: if any req bit is set, grant one round-robin starting at pointer rr; latch index, key, value, kind; next state LAUNCH.
REQ-022 rr becomes (granted index + 1) mod 4 on each grant; rr = 0 after reset.
REQ-023 LAUNCH lasts exactly one cycle: st_enable=1; st_write=1 for create/issue/transfer, 0 for refer; st_signal per REQ-014; next state WAIT with timer=0.
REQ-024 st_enable and st_write are 0 in every state except LAUNCH.
REQ-025 st_key, st_value and st_kind hold latched values from LAUNCH until the next grant.
REQ-026 st_ready in any state other than WAIT is ignored.
REQ-027 WAIT: if st_ready=1, capture st_rdata into rsp_value, set rsp_ok=1 and go to RESP.
REQ-028 WAIT: otherwise increment timer; when timer reaches TIMEOUT-1 without st_ready, set rsp_value=0, rsp_ok=0 and go to RESP.
REQ-029 st_ready on the same cycle as the timeout boundary counts as success.
REQ-030 RESP lasts one cycle: ack[granted]=1 and all other ack bits 0; ops_done increments on rsp_ok=1, timeouts increments on rsp_ok=0; next state IDLE.
REQ-031 ops_done and timeouts saturate at all-ones and do not wrap.
REQ-032 rsp_value and rsp_ok hold their values until the next RESP.
REQ-033 Minimum latency: req sampled in IDLE at edge N, LAUNCH in cycle N+1, st_ready at N+2, ack visible in cycle N+3 (4 cycles request to ack).
REQ-034 Requests arriving while busy wait; only IDLE arbitrates.
REQ-035 A requester dropping req mid-operation does not cancel it; its ack still pulses.
REQ-036 IDLE with req=0: no state change and no store activity.

Reset
REQ-037 Reset to IDLE; clear rr, timer, ack, st_enable, st_write, st_signal, st_key, st_value, st_kind, rsp_value, rsp_ok, busy, ops_done and timeouts to 0.
REQ-038 Reset asserted mid-operation aborts it on the next edge: no ack pulse, no counter increment, and a st_ready arriving after reset is ignored.
REQ-039 Reset has priority over every other transition.

Verification
REQ-040 Single create: req=1000, key=0x0000_00AA, value=0x10, st_ready two cycles after LAUNCH with rdata=0x10 -> st_signal=01, st_write=1 for one cycle, ack=1000, rsp_ok=1, rsp_value=0x10, ops_done=1.
REQ-041 Round-robin: req=1111 held, store responds immediately -> grant order bit0, bit1, bit2, bit3, bit0; each ack is a single-cycle pulse.
REQ-042 Refer read: req=0100, st_ready with rdata=0xDEAD_BEEF -> st_write=0, st_signal=00, rsp_value=0xDEADBEEF.
REQ-043 Timeout: TIMEOUT=16, st_ready never asserted -> ack in RESP 16 cycles after WAIT entry, rsp_ok=0, rsp_value=0, timeouts=1, ops_done unchanged.
REQ-044 Reset in WAIT, then st_ready pulse -> no ack, busy=0, counters 0, next req handled normally starting from rr=0.
REQ-045 Saturation: force 65535 successful operations, then one more -> ops_done stays 0xFFFF.
